led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Drives a bank of WIDTH LEDs with a moving pattern. While running, a divider
// counts clock cycles and every period_i+1 cycles the pattern advances by one
// position: rotate left, rotate right, bounce between the two end LEDs, or hold.
// While idle, a new pattern can be loaded through a valid/ready handshake.
//
// Ports
//   clk_i           single clock, everything updates on the rising edge
//   reset_i         synchronous reset, active low
//   enable_i        level-sensitive run request (IDLE <-> RUN)
//   mode_i          00 rotate left, 01 rotate right, 10 bounce, 11 hold
//   period_i        step interval, pattern advances every period_i+1 cycles
//   load_valid_i    pattern load request
//   load_pattern_i  pattern to load (all zeros loads INIT instead)
//   load_ready_o    high in IDLE once out of reset; load taken on valid&&ready
//   leds_o          current pattern (registered)
//   step_o          one-cycle pulse alongside each new pattern
//   wrap_o          one-cycle pulse when a sequence completes
//   busy_o          high in RUN
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int               WIDTH = 4,
    parameter int               CNT_W = 32,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_pattern_i,
    output logic             load_ready_o,
    output logic [WIDTH-1:0] leds_o,
    output logic             step_o,
    output logic             wrap_o,
    output logic             busy_o
);

    localparam int SC_W = $clog2(WIDTH);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             dirRight_q, dirRight_d;
    logic [SC_W-1:0]  stepCnt_q, stepCnt_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             outOfReset_q;

    logic [WIDTH-1:0] rotLeft, rotRight;
    logic             loadFire;

    assign rotLeft  = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
    assign rotRight = {leds_q[0], leds_q[WIDTH-1:1]};

    // outOfReset_q keeps load_ready low until the first edge after reset
    // has been released, so no load can slip in during reset.
    assign load_ready_o = (state_q == IDLE) && outOfReset_q;
    assign loadFire     = load_valid_i && load_ready_o;
    assign busy_o       = (state_q == RUN);
    assign leds_o       = leds_q;
    assign step_o       = step_q;
    assign wrap_o       = wrap_q;

    // Next-state logic. The divider only runs in RUN; when it reaches period
    // the pattern advances according to the mode sampled on that cycle.
    // Rotate modes count steps modulo WIDTH to find sequence completion,
    // bounce flags completion on each direction reversal instead.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        leds_d     = leds_q;
        dirRight_d = dirRight_q;
        stepCnt_d  = stepCnt_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (loadFire) begin
                    leds_d     = (load_pattern_i == '0) ? INIT : load_pattern_i;
                    dirRight_d = 1'b0;
                    stepCnt_d  = '0;
                end
                if (enable_i) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q >= period_i) begin
                    count_d = '0;
                    step_d  = 1'b1;
                    case (mode_i)
                        2'b00, 2'b01: begin
                            leds_d     = (mode_i == 2'b00) ? rotLeft : rotRight;
                            dirRight_d = (mode_i == 2'b01);
                            if (stepCnt_q == STEP_LAST) begin
                                stepCnt_d = '0;
                                wrap_d    = 1'b1;
                            end else begin
                                stepCnt_d = stepCnt_q + 1'b1;
                            end
                        end
                        2'b10: begin
                            if (!dirRight_q && leds_q[WIDTH-1]) begin
                                dirRight_d = 1'b1;
                                leds_d     = rotRight;
                                wrap_d     = 1'b1;
                            end else if (dirRight_q && leds_q[0]) begin
                                dirRight_d = 1'b0;
                                leds_d     = rotLeft;
                                wrap_d     = 1'b1;
                            end else begin
                                leds_d = dirRight_q ? rotRight : rotLeft;
                            end
                        end
                        default: begin
                            leds_d = leds_q;
                        end
                    endcase
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset wins over any
    // pending step, load or enable on the same edge.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            leds_q       <= INIT;
            dirRight_q   <= 1'b0;
            stepCnt_q    <= '0;
            step_q       <= 1'b0;
            wrap_q       <= 1'b0;
            outOfReset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            leds_q       <= leds_d;
            dirRight_q   <= dirRight_d;
            stepCnt_q    <= stepCnt_d;
            step_q       <= step_d;
            wrap_q       <= wrap_d;
            outOfReset_q <= 1'b1;
        end
    end

endmodule
